oflow_iou_dispatcher: RTL and testbench
=======================================

OFLOW_IOU_DISPATCHER -- requirements
Module: oflow_iou_dispatcher

Interface
REQ-001 SHALL have parameter MAX_HIST, default 16, meaning the depth of the history buffer in entries (index width clog2(MAX_HIST)=4).
REQ-002 SHALL have ports clk input 1 (clock) and reset_N input 1 (reset, asynchronous, active-high).
REQ-003 SHALL have ports start input 1 (begin matching one frame-k bbox), num_history input 5 (valid history entries), bbox_k input 44 ({X_TL,Y_TL,X_BR,Y_BR}, 11b each), w_k input 11, h_k input 11.
REQ-004 SHALL have history read port hist_rd_en output 1, hist_rd_addr output 4, hist_rd_data input 66 ({pos[43:0], w[10:0], h[10:0]}), with read data valid exactly one cycle after hist_rd_en.
REQ-005 SHALL have IoU request port iou_req_valid output 1, iou_req_ready input 1, req_pos_k output 44, req_pos_hist output 44, req_w_k/req_h_k/req_w_hist/req_h_hist output 11 each.
REQ-006 SHALL have IoU response port iou_rsp_valid input 1, iou_rsp input 22 (cost: lower means better overlap).
REQ-007 SHALL have result ports busy output 1, done output 1, match_found output 1, best_idx output 4, best_cost output 22.

Function
REQ-008 SHALL implement FSM states IDLE, READ, ISSUE, WAIT, DONE.
REQ-009 IDLE: on start=1, SHALL latch bbox_k/w_k/h_k and min(num_history, MAX_HIST), clear index to 0, set best_cost=22'h3FFFFF, best_idx=0; go READ if count>0, else DONE.
REQ-010 READ: SHALL assert hist_rd_en for one cycle with hist_rd_addr=index, then go ISSUE.
REQ-011 ISSUE: SHALL latch hist_rd_data in its first cycle, drive iou_req_valid=1 with stable payload until iou_req_valid&&iou_req_ready, then go WAIT.
REQ-012 Request payload SHALL NOT change while iou_req_valid=1 and not accepted.
REQ-013 WAIT: on iou_rsp_valid=1, SHALL update best_cost/best_idx if iou_rsp < best_cost (strict; ties keep lower index), increment index, go DONE if index+1==count else READ.
REQ-014 Only one request SHALL be outstanding; iou_rsp_valid outside WAIT SHALL be ignored.
REQ-015 DONE: SHALL pulse done=1 for exactly one cycle, then return to IDLE; best_idx, best_cost, match_found SHALL hold until the next accepted start.
REQ-016 busy SHALL be 1 in READ, ISSUE, WAIT, DONE and 0 in IDLE; start while busy=1 SHALL be ignored.
REQ-017 With iou_req_ready=1 and response one cycle after acceptance, each entry SHALL take 3 cycles (READ, ISSUE, WAIT); done SHALL assert 3*N+1 cycles after the start cycle.
REQ-018 match_found SHALL be 1 iff at least one entry was evaluated (subject to REQ-022).

Reset
REQ-019 On reset_N=1, state SHALL be IDLE and all outputs 0 except best_cost=22'h3FFFFF.
REQ-020 Reset asserted mid-operation SHALL abort immediately; no done pulse SHALL follow reset release.

Configuration
REQ-021 Macro OFLOW_IOU_THRESH_EN SHALL add input cost_thresh (22 bits), sampled at start.
REQ-022 With OFLOW_IOU_THRESH_EN defined, match_found SHALL be 1 iff best_cost <= latched cost_thresh; without it, cost_thresh SHALL not exist and REQ-018 applies unmodified.

Verification
REQ-023 num_history=0, start -> done one cycle later, match_found=0, best_idx=0, best_cost=22'h3FFFFF, no hist_rd_en.
REQ-024 num_history=3, costs {500,200,900}, ready=1, 1-cycle rsp -> done at cycle 10, best_idx=1, best_cost=200, match_found=1.
REQ-025 costs {300,300}, iou_req_ready held low 5 cycles per request -> payload stable throughout, best_idx=0, best_cost=300.
REQ-026 num_history=20 -> exactly 16 reads (addr 0..15), done asserted once.
REQ-027 reset_N pulsed while in WAIT of entry 2 -> IDLE, busy=0, no done, best_cost=22'h3FFFFF; start while busy ignored.
REQ-028 OFLOW_IOU_THRESH_EN defined, cost_thresh=100, costs {150,120} -> best_cost=120, match_found=0.

Source files
------------

// File: rtl/oflow_iou_dispatcher.sv
// Matches one frame-k bbox against the history buffer: one IoU request per entry, keeps the lowest cost.
// Optional macro OFLOW_IOU_THRESH_EN adds cost_thresh; match_found then also requires best_cost <= cost_thresh.
module oflow_iou_dispatcher #(
  parameter int MAX_HIST = 16
) (
  input  logic                        clk,
  input  logic                        reset_N,
  input  logic                        start,
  input  logic [4:0]                  num_history,
  input  logic [43:0]                 bbox_k,
  input  logic [10:0]                 w_k,
  input  logic [10:0]                 h_k,
`ifdef OFLOW_IOU_THRESH_EN
  input  logic [21:0]                 cost_thresh,
`endif
  output logic                        hist_rd_en,
  output logic [$clog2(MAX_HIST)-1:0] hist_rd_addr,
  input  logic [65:0]                 hist_rd_data,
  output logic                        iou_req_valid,
  input  logic                        iou_req_ready,
  output logic [43:0]                 req_pos_k,
  output logic [43:0]                 req_pos_hist,
  output logic [10:0]                 req_w_k,
  output logic [10:0]                 req_h_k,
  output logic [10:0]                 req_w_hist,
  output logic [10:0]                 req_h_hist,
  input  logic                        iou_rsp_valid,
  input  logic [21:0]                 iou_rsp,
  output logic                        busy,
  output logic                        done,
  output logic                        match_found,
  output logic [$clog2(MAX_HIST)-1:0] best_idx,
  output logic [21:0]                 best_cost
);

  localparam int IDXW = $clog2(MAX_HIST);
  localparam int CNTW = IDXW + 1;
  localparam logic [21:0] COST_MAX = 22'h3FFFFF;

  typedef enum logic [2:0] {IDLE, READ, ISSUE, WAIT, DONE} state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] index_q, index_d, count_q, count_d;
  logic [43:0]     bboxK_q, bboxK_d;
  logic [10:0]     wK_q, wK_d, hK_q, hK_d;
  logic [65:0]     hist_q, hist_d;
  logic            issueFirst_q, issueFirst_d;
  logic [21:0]     bestCost_q, bestCost_d;
  logic [IDXW-1:0] bestIdx_q, bestIdx_d;
  logic            match_q, match_d;
  logic [65:0]     histSel;
  logic            candBetter;
  logic [CNTW-1:0] clampedCount;
`ifdef OFLOW_IOU_THRESH_EN
  logic [21:0]     thresh_q, thresh_d;
  logic [21:0]     candCost;
`endif

  assign clampedCount = (32'(num_history) > MAX_HIST) ? CNTW'(MAX_HIST) : CNTW'(num_history);
  // Read data is only present in the first ISSUE cycle, so it drives the payload directly until latched.
  assign histSel      = issueFirst_q ? hist_rd_data : hist_q;
  assign candBetter   = iou_rsp < bestCost_q;
`ifdef OFLOW_IOU_THRESH_EN
  assign candCost     = candBetter ? iou_rsp : bestCost_q;
`endif

  assign hist_rd_addr = index_q[IDXW-1:0];
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign req_pos_k    = bboxK_q;
  assign req_w_k      = wK_q;
  assign req_h_k      = hK_q;
  assign req_pos_hist = histSel[65:22];
  assign req_w_hist   = histSel[21:11];
  assign req_h_hist   = histSel[10:0];
  assign match_found  = match_q;
  assign best_idx     = bestIdx_q;
  assign best_cost    = bestCost_q;

  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    count_d       = count_q;
    bboxK_d       = bboxK_q;
    wK_d          = wK_q;
    hK_d          = hK_q;
    hist_d        = hist_q;
    issueFirst_d  = issueFirst_q;
    bestCost_d    = bestCost_q;
    bestIdx_d     = bestIdx_q;
    match_d       = match_q;
`ifdef OFLOW_IOU_THRESH_EN
    thresh_d      = thresh_q;
`endif
    hist_rd_en    = 1'b0;
    iou_req_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bboxK_d    = bbox_k;
          wK_d       = w_k;
          hK_d       = h_k;
          count_d    = clampedCount;
          index_d    = '0;
          bestCost_d = COST_MAX;
          bestIdx_d  = '0;
          match_d    = 1'b0;
`ifdef OFLOW_IOU_THRESH_EN
          thresh_d   = cost_thresh;
`endif
          state_d    = (clampedCount != '0) ? READ : DONE;
        end
      end
      READ: begin
        hist_rd_en   = 1'b1;
        issueFirst_d = 1'b1;
        state_d      = ISSUE;
      end
      ISSUE: begin
        iou_req_valid = 1'b1;
        issueFirst_d  = 1'b0;
        if (issueFirst_q) hist_d = hist_rd_data;
        if (iou_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (iou_rsp_valid) begin
          // Strict compare so a tie keeps the earlier (lower) index.
          if (candBetter) begin
            bestCost_d = iou_rsp;
            bestIdx_d  = index_q[IDXW-1:0];
          end
`ifdef OFLOW_IOU_THRESH_EN
          match_d = (candCost <= thresh_q);
`else
          match_d = 1'b1;
`endif
          index_d = index_q + CNTW'(1);
          state_d = (index_q + CNTW'(1) == count_q) ? DONE : READ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_N) begin
    if (reset_N) begin
      state_q      <= IDLE;
      index_q      <= '0;
      count_q      <= '0;
      bboxK_q      <= '0;
      wK_q         <= '0;
      hK_q         <= '0;
      hist_q       <= '0;
      issueFirst_q <= 1'b0;
      bestCost_q   <= COST_MAX;
      bestIdx_q    <= '0;
      match_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      count_q      <= count_d;
      bboxK_q      <= bboxK_d;
      wK_q         <= wK_d;
      hK_q         <= hK_d;
      hist_q       <= hist_d;
      issueFirst_q <= issueFirst_d;
      bestCost_q   <= bestCost_d;
      bestIdx_q    <= bestIdx_d;
      match_q      <= match_d;
    end
  end

`ifdef OFLOW_IOU_THRESH_EN
  always_ff @(posedge clk or posedge reset_N) begin
    if (reset_N) thresh_q <= '0;
    else         thresh_q <= thresh_d;
  end
`endif

endmodule

// File: tb/tb_oflow_iou_dispatcher.sv
// Directed bench for oflow_iou_dispatcher: history RAM and IoU engine models with hand-computed results.
module tb_oflow_iou_dispatcher;

  logic        clk;
  logic        reset_N;
  logic        start;
  logic [4:0]  num_history;
  logic [43:0] bbox_k;
  logic [10:0] w_k, h_k;
`ifdef OFLOW_IOU_THRESH_EN
  logic [21:0] cost_thresh;
`endif
  logic        hist_rd_en;
  logic [3:0]  hist_rd_addr;
  logic [65:0] hist_rd_data;
  logic        iou_req_valid, iou_req_ready;
  logic [43:0] req_pos_k, req_pos_hist;
  logic [10:0] req_w_k, req_h_k, req_w_hist, req_h_hist;
  logic        iou_rsp_valid;
  logic [21:0] iou_rsp;
  logic        busy, done, match_found;
  logic [3:0]  best_idx;
  logic [21:0] best_cost;

  int vectors = 0;
  int miscompares = 0;
  int cycleCnt = 0;
  int readyDelay = 0;
  bit injectRsp = 0;
  int lastRdAddr = 0;
  int doneCount = 0;
  int runLatency = -1;
  bit gotDone = 0;
  bit acceptSeen = 0;
  int rdAddrs[$];
  logic [65:0] histMem [0:15];
  logic [21:0] costTab [0:15];
  logic [65:0] expK;

  oflow_iou_dispatcher #(.MAX_HIST(16)) dut (
    .clk(clk), .reset_N(reset_N), .start(start), .num_history(num_history),
    .bbox_k(bbox_k), .w_k(w_k), .h_k(h_k),
`ifdef OFLOW_IOU_THRESH_EN
    .cost_thresh(cost_thresh),
`endif
    .hist_rd_en(hist_rd_en), .hist_rd_addr(hist_rd_addr), .hist_rd_data(hist_rd_data),
    .iou_req_valid(iou_req_valid), .iou_req_ready(iou_req_ready),
    .req_pos_k(req_pos_k), .req_pos_hist(req_pos_hist),
    .req_w_k(req_w_k), .req_h_k(req_h_k), .req_w_hist(req_w_hist), .req_h_hist(req_h_hist),
    .iou_rsp_valid(iou_rsp_valid), .iou_rsp(iou_rsp),
    .busy(busy), .done(done), .match_found(match_found), .best_idx(best_idx), .best_cost(best_cost)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cycleCnt++;
  end

  task automatic checkOutput(input string tag, input logic [131:0] got, input logic [131:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic expMatch(input logic evaluated, input logic [21:0] cost);
`ifdef OFLOW_IOU_THRESH_EN
    return evaluated && (cost <= cost_thresh);
`else
    return evaluated;
`endif
  endfunction

  // Mid-cycle monitor: read addresses, done pulses, and request payload against the history model.
  initial begin
    logic [131:0] curPayload, prevPayload;
    bit prevValid, prevAccepted;
    prevPayload = '0;
    prevValid = 0;
    prevAccepted = 0;
    forever begin
      @(negedge clk);
      if (hist_rd_en) begin
        rdAddrs.push_back(int'(hist_rd_addr));
        lastRdAddr = int'(hist_rd_addr);
      end
      if (done) doneCount++;
      if (iou_req_valid) begin
        curPayload = {req_pos_k, req_pos_hist, req_w_k, req_h_k, req_w_hist, req_h_hist};
        if (prevValid && !prevAccepted) checkOutput("payloadStable", curPayload, prevPayload);
        checkOutput("reqHist", {req_pos_hist, req_w_hist, req_h_hist}, histMem[lastRdAddr]);
        checkOutput("reqK", {req_pos_k, req_w_k, req_h_k}, expK);
        prevPayload = curPayload;
      end
      prevValid = iou_req_valid;
      prevAccepted = iou_req_ready;
      acceptSeen = iou_req_valid && iou_req_ready;
    end
  end

  // History RAM (data one cycle after hist_rd_en, junk otherwise) and IoU engine (response one cycle after acceptance).
  initial begin
    logic [95:0] junk;
    bit pendRd;
    int pendAddr;
    int issueCycles;
    pendRd = 0;
    pendAddr = 0;
    issueCycles = 0;
    hist_rd_data = '0;
    iou_req_ready = 1'b1;
    iou_rsp_valid = 1'b0;
    iou_rsp = '0;
    forever begin
      @(posedge clk);
      #1;
      junk = {$urandom, $urandom, $urandom};
      hist_rd_data = pendRd ? histMem[pendAddr] : junk[65:0];
      pendRd = hist_rd_en;
      pendAddr = int'(hist_rd_addr);
      if (iou_req_valid) begin
        iou_req_ready = (issueCycles >= readyDelay);
        issueCycles++;
      end else begin
        issueCycles = 0;
        iou_req_ready = (readyDelay == 0);
      end
      if (acceptSeen) begin
        iou_rsp_valid = 1'b1;
        iou_rsp = costTab[lastRdAddr];
      end else if (injectRsp && iou_req_valid) begin
        iou_rsp_valid = 1'b1;
        iou_rsp = 22'd1;
      end else begin
        iou_rsp_valid = 1'b0;
        iou_rsp = junk[95:74];
      end
    end
  end

  task automatic applyStimulus(input int n, input int rdyDelay, input bit inject, input bit midStart);
    int startCycle;
    readyDelay = rdyDelay;
    injectRsp = inject;
    @(negedge clk);
    num_history = 5'(n);
    bbox_k = {11'(n + 1), 11'(n + 2), 11'(n + 3), 11'(n + 4)};
    w_k = 11'(n + 100);
    h_k = 11'(n + 200);
    expK = {bbox_k, w_k, h_k};
    rdAddrs.delete();
    doneCount = 0;
    gotDone = 0;
    runLatency = -1;
    start = 1'b1;
    startCycle = cycleCnt;
    for (int i = 0; i < 300 && !gotDone; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start = 1'b0;
        checkOutput("busyRun", busy, 1);
      end
      if (midStart && i == 3) begin
        start = 1'b1;
        num_history = 5'd0;
        bbox_k = ~bbox_k;
      end
      if (midStart && i == 4) begin
        start = 1'b0;
        num_history = 5'(n);
      end
      if (done) begin
        gotDone = 1;
        runLatency = cycleCnt - startCycle;
      end
    end
    if (!gotDone) checkOutput("doneTimeout", 0, 1);
    repeat (4) @(negedge clk);
    injectRsp = 0;
  endtask

  task automatic checkRun(input int expReads, input int expIdx, input logic [21:0] expCost,
                          input logic expM, input int expLat);
    if (expLat >= 0) checkOutput("doneLatency", runLatency, expLat);
    checkOutput("doneOnce", doneCount, 1);
    checkOutput("readCount", rdAddrs.size(), expReads);
    checkOutput("bestIdx", best_idx, expIdx);
    checkOutput("bestCost", best_cost, expCost);
    checkOutput("matchFound", match_found, expM);
    checkOutput("idleBusy", busy, 0);
  endtask

  initial begin
    bit found;
    reset_N = 1'b1;
    start = 1'b0;
    num_history = '0;
    bbox_k = '0;
    w_k = '0;
    h_k = '0;
    expK = '0;
`ifdef OFLOW_IOU_THRESH_EN
    cost_thresh = 22'h3FFFFE;
`endif
    for (int i = 0; i < 16; i++) begin
      histMem[i] = {11'(i * 7 + 3), 11'(i * 5 + 1), 11'(i * 3 + 60), 11'(i + 90), 11'(i + 20), 11'(i + 40)};
      costTab[i] = 22'(1000 - i * 10);
    end

    repeat (3) @(negedge clk);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstMatch", match_found, 0);
    checkOutput("rstIdx", best_idx, 0);
    checkOutput("rstCost", best_cost, 22'h3FFFFF);
    checkOutput("rstRdEn", hist_rd_en, 0);
    checkOutput("rstReqValid", iou_req_valid, 0);
    checkOutput("rstPosK", req_pos_k, 0);
    reset_N = 1'b0;
    repeat (2) @(negedge clk);

    // Empty history: straight to DONE.
    applyStimulus(0, 0, 0, 0);
    checkRun(0, 0, 22'h3FFFFF, expMatch(0, 22'h3FFFFF), 1);

    // Three entries, minimum in the middle; a start while busy must be ignored.
    costTab[0] = 22'd500; costTab[1] = 22'd200; costTab[2] = 22'd900;
    applyStimulus(3, 0, 0, 1);
    checkRun(3, 1, 22'd200, expMatch(1, 22'd200), 10);

    // Tie with ready stalled 5 cycles per request and stray responses during ISSUE.
    costTab[0] = 22'd300; costTab[1] = 22'd300;
    applyStimulus(2, 5, 1, 0);
    checkRun(2, 0, 22'd300, expMatch(1, 22'd300), -1);

    // Single entry whose cost equals the initial best: no update, but still evaluated.
    costTab[0] = 22'h3FFFFF;
    applyStimulus(1, 0, 0, 0);
    checkRun(1, 0, 22'h3FFFFF, expMatch(1, 22'h3FFFFF), 4);

    // Oversized num_history clamps to 16; descending costs put the minimum at the last entry.
    for (int i = 0; i < 16; i++) costTab[i] = 22'(1000 - i * 10);
    applyStimulus(20, 0, 0, 0);
    checkRun(16, 15, 22'd850, expMatch(1, 22'd850), 49);
    for (int i = 0; i < 16; i++) begin
      if (i < rdAddrs.size()) checkOutput("rdAddr", rdAddrs[i], i);
    end

    // Reset during WAIT of entry 2 aborts without a done pulse.
    costTab[0] = 22'd400; costTab[1] = 22'd300; costTab[2] = 22'd200; costTab[3] = 22'd100;
    readyDelay = 0;
    @(negedge clk);
    num_history = 5'd4;
    expK = {bbox_k, w_k, h_k};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (lastRdAddr == 2 && busy && !hist_rd_en && !iou_req_valid && !done) found = 1;
    end
    checkOutput("reachWait2", found, 1);
    reset_N = 1'b1;
    #1;
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortDone", done, 0);
    checkOutput("abortCost", best_cost, 22'h3FFFFF);
    checkOutput("abortIdx", best_idx, 0);
    checkOutput("abortMatch", match_found, 0);
    doneCount = 0;
    @(negedge clk);
    reset_N = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("noDoneAfterReset", doneCount, 0);
    checkOutput("idleAfterReset", busy, 0);

    // Normal operation resumes after the abort.
    costTab[0] = 22'd42;
    applyStimulus(1, 0, 0, 0);
    checkRun(1, 0, 22'd42, expMatch(1, 22'd42), 4);

`ifdef OFLOW_IOU_THRESH_EN
    // Best cost above the threshold gives no match; equal to it does.
    costTab[0] = 22'd150; costTab[1] = 22'd120;
    cost_thresh = 22'd100;
    applyStimulus(2, 0, 0, 0);
    checkRun(2, 1, 22'd120, 1'b0, 7);
    cost_thresh = 22'd120;
    applyStimulus(2, 0, 0, 0);
    checkRun(2, 1, 22'd120, 1'b1, 7);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
